// File: rtl/lzc_index_collector.sv
// ============================================================================
// lzc_index_collector : rebuilds a bit vector from a stream of LZC-format
//                       indices; a last beat hands it to a registered output.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc_index_collector #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MODE       = 1'b0,
   parameter int unsigned BEAT_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CNT_WIDTH-1:0]  idx_i,
   input  logic                  empty_i,
   input  logic                  last_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [WIDTH-1:0]      vec_o,
   output logic [BEAT_WIDTH-1:0] beats_o,
   output logic                  err_oor_o,
   output logic                  err_dup_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   // One extra bit so WIDTH itself is representable for the range compare.
   localparam logic [CNT_WIDTH:0] c_width_ext = (CNT_WIDTH + 1)'(WIDTH);
   localparam logic [CNT_WIDTH:0] c_last_bit  = (CNT_WIDTH + 1)'(WIDTH - 1);

   logic [WIDTH-1:0]      acc_vec_q,   acc_vec_d;
   logic [BEAT_WIDTH-1:0] acc_beats_q, acc_beats_d;
   logic                  acc_oor_q,   acc_oor_d;
   logic                  acc_dup_q,   acc_dup_d;

   logic [WIDTH-1:0]      out_vec_q,   out_vec_d;
   logic [BEAT_WIDTH-1:0] out_beats_q, out_beats_d;
   logic                  out_oor_q,   out_oor_d;
   logic                  out_dup_q,   out_dup_d;
   logic                  out_valid_q, out_valid_d;

   logic [CNT_WIDTH:0]    w_idx_ext;
   logic [CNT_WIDTH:0]    w_tgt;
   logic                  w_in_range;
   logic                  w_set;
   logic [WIDTH-1:0]      w_mask;
   logic                  w_accept;
   logic [WIDTH-1:0]      w_merge_vec;
   logic [BEAT_WIDTH-1:0] w_merge_beats;
   logic                  w_merge_oor;
   logic                  w_merge_dup;

   assign ready_o    = !out_valid_q || ready_i;
   assign w_accept   = valid_i && ready_o;

   assign w_idx_ext  = {1'b0, idx_i};
   assign w_in_range = (w_idx_ext < c_width_ext);
   assign w_set      = !empty_i && w_in_range;

   // Target bit is only meaningful when w_set; out-of-range MSB indices wrap harmlessly.
   if (MODE) begin : g_msb_first
      assign w_tgt = c_last_bit - w_idx_ext;
   end else begin : g_lsb_first
      assign w_tgt = w_idx_ext;
   end

   for (genvar k = 0; k < int'(WIDTH); k++) begin : g_mask
      assign w_mask[k] = w_set && (w_tgt == (CNT_WIDTH + 1)'(k));
   end

   assign w_merge_vec   = acc_vec_q | w_mask;
   assign w_merge_dup   = acc_dup_q | (|(acc_vec_q & w_mask));
   assign w_merge_oor   = acc_oor_q | (!empty_i && !w_in_range);
   assign w_merge_beats = (&acc_beats_q) ? acc_beats_q : acc_beats_q + 1'b1;

   always_comb begin
      acc_vec_d   = acc_vec_q;
      acc_beats_d = acc_beats_q;
      acc_oor_d   = acc_oor_q;
      acc_dup_d   = acc_dup_q;
      out_vec_d   = out_vec_q;
      out_beats_d = out_beats_q;
      out_oor_d   = out_oor_q;
      out_dup_d   = out_dup_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && ready_i) begin
         out_valid_d = 1'b0;
      end

      if (w_accept) begin
         if (last_i) begin
            // A draining output may be reloaded in the same cycle.
            out_vec_d   = w_merge_vec;
            out_beats_d = w_merge_beats;
            out_oor_d   = w_merge_oor;
            out_dup_d   = w_merge_dup;
            out_valid_d = 1'b1;
            acc_vec_d   = '0;
            acc_beats_d = '0;
            acc_oor_d   = 1'b0;
            acc_dup_d   = 1'b0;
         end else begin
            acc_vec_d   = w_merge_vec;
            acc_beats_d = w_merge_beats;
            acc_oor_d   = w_merge_oor;
            acc_dup_d   = w_merge_dup;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_vec_q   <= '0;
         acc_beats_q <= '0;
         acc_oor_q   <= 1'b0;
         acc_dup_q   <= 1'b0;
         out_vec_q   <= '0;
         out_beats_q <= '0;
         out_oor_q   <= 1'b0;
         out_dup_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_vec_q   <= acc_vec_d;
         acc_beats_q <= acc_beats_d;
         acc_oor_q   <= acc_oor_d;
         acc_dup_q   <= acc_dup_d;
         out_vec_q   <= out_vec_d;
         out_beats_q <= out_beats_d;
         out_oor_q   <= out_oor_d;
         out_dup_q   <= out_dup_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign vec_o     = out_vec_q;
   assign beats_o   = out_beats_q;
   assign err_oor_o = out_oor_q;
   assign err_dup_o = out_dup_q;
   assign valid_o   = out_valid_q;

endmodule

`default_nettype wire
